// File: rtl/month_year_counter_pkg.sv
// Shared calendar constants and the leap-year helper used by the month/year stage.
package calendar_pkg;

  localparam int MONTHS_PER_YEAR  = 12;
  localparam int MONTH_MIN        = 1;
  localparam int YEAR_MAX_DEFAULT = 99;
  localparam int MONTH_W          = 6;
  localparam int YEAR_W           = 7;

  // Divisible-by-4 is exact for 2000..2099 (2000 is a leap year).
  function automatic logic is_leap(input logic [YEAR_W-1:0] year);
    return (year[1:0] == 2'b00);
  endfunction

endpackage

// File: rtl/month_year_counter_if.sv
// Mode/setup controls from the operator side and calendar outputs to the day counter.
interface month_year_counter_if;
  import calendar_pkg::*;

  logic               display;
  logic               done_day;
  logic               setup_month;
  logic               setup_year;
  logic               inc_dec;
  logic               tick;
  logic [MONTH_W-1:0] curr_month;
  logic [YEAR_W-1:0]  curr_year;
  logic               nhuan;
  logic               done_month;
  logic               done_century;

  modport master (
    output display, done_day, setup_month, setup_year, inc_dec, tick,
    input  curr_month, curr_year, nhuan, done_month, done_century
  );

  modport slave (
    input  display, done_day, setup_month, setup_year, inc_dec, tick,
    output curr_month, curr_year, nhuan, done_month, done_century
  );
endinterface

// File: rtl/month_year_counter_wrap.sv
// Up/down counter over MIN..MAX that wraps at either end; wrap flags a wrapping step.
module wrap_updown_counter #(
  parameter int W   = 6,
  parameter int MIN = 1,
  parameter int MAX = 12,
  parameter int RST = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en,
  input  logic         up,
  input  logic         load_rst,
  output logic [W-1:0] q,
  output logic         wrap
);

  localparam logic [W-1:0] MIN_V = W'(MIN);
  localparam logic [W-1:0] MAX_V = W'(MAX);
  localparam logic [W-1:0] RST_V = W'(RST);

  logic [W-1:0] q_reg;

  assign q    = q_reg;
  assign wrap = en & (up ? (q_reg == MAX_V) : (q_reg == MIN_V));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q_reg <= RST_V;
    end else if (load_rst) begin
      q_reg <= RST_V;
    end else if (en) begin
      if (wrap)
        q_reg <= up ? MIN_V : MAX_V;
      else
        q_reg <= up ? q_reg + W'(1) : q_reg - W'(1);
    end
  end

endmodule

// File: rtl/month_year_counter.sv
// Month/year calendar stage: advances on the day counter's end-of-month edge,
// or steps month/year manually in setup mode.
module month_year_counter
  import calendar_pkg::*;
#(
  parameter int YEAR_MAX    = YEAR_MAX_DEFAULT,
  parameter int MONTH_RESET = 1,
  parameter int YEAR_RESET  = 0
) (
  input  logic                 clk,
  input  logic                 rst,
  month_year_counter_if.slave  bus
);

  localparam logic [MONTH_W-1:0] MONTH_MAX_V = MONTH_W'(MONTHS_PER_YEAR);
  localparam logic [YEAR_W-1:0]  YEAR_MAX_V  = YEAR_W'(YEAR_MAX);
  localparam logic [YEAR_W-1:0]  YEAR_MIN_V  = '0;
  localparam logic [YEAR_W-1:0]  YEAR_RST_V  = YEAR_W'(YEAR_RESET);

  logic [MONTH_W-1:0] month_q;
  logic [YEAR_W-1:0]  year_q;
  logic [YEAR_W-1:0]  year_next;
  logic               done_day_q_reg;
  logic               done_month_reg;
  logic               done_century_reg;
  logic               nhuan_reg;
  logic               advance, run_step, set_month, set_year;
  logic               month_en, year_en, step_up;
  logic               month_wrap, year_wrap, illegal;

  assign advance   = bus.done_day & ~done_day_q_reg;
  assign run_step  = ~bus.display & advance;
  assign set_month = bus.display & bus.tick & ~bus.setup_month;
  assign set_year  = bus.display & bus.tick & bus.setup_month & ~bus.setup_year;
  assign step_up   = bus.display ? bus.inc_dec : 1'b1;
  assign month_en  = run_step | set_month;
  assign year_en   = (run_step & month_wrap) | set_year;
  assign illegal   = (month_q == '0) || (month_q > MONTH_MAX_V) || (year_q > YEAR_MAX_V);

  wrap_updown_counter #(
    .W(MONTH_W), .MIN(MONTH_MIN), .MAX(MONTHS_PER_YEAR), .RST(MONTH_RESET)
  ) u_month (
    .clk(clk), .rst(rst), .en(month_en), .up(step_up), .load_rst(illegal),
    .q(month_q), .wrap(month_wrap)
  );

  wrap_updown_counter #(
    .W(YEAR_W), .MIN(0), .MAX(YEAR_MAX), .RST(YEAR_RESET)
  ) u_year (
    .clk(clk), .rst(rst), .en(year_en), .up(step_up), .load_rst(illegal),
    .q(year_q), .wrap(year_wrap)
  );

  // Mirror of the year counter's next value so nhuan is never a cycle stale.
  always_comb begin
    year_next = year_q;
    if (illegal)
      year_next = YEAR_RST_V;
    else if (year_en) begin
      if (year_wrap)
        year_next = step_up ? YEAR_MIN_V : YEAR_MAX_V;
      else
        year_next = step_up ? year_q + YEAR_W'(1) : year_q - YEAR_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      done_day_q_reg   <= 1'b0;
      done_month_reg   <= 1'b0;
      done_century_reg <= 1'b0;
      nhuan_reg        <= is_leap(YEAR_RST_V);
    end else begin
      done_day_q_reg   <= bus.done_day;
      done_month_reg   <= run_step & month_wrap & ~illegal;
      done_century_reg <= run_step & month_wrap & year_wrap & ~illegal;
      nhuan_reg        <= is_leap(year_next);
    end
  end

  assign bus.curr_month   = month_q;
  assign bus.curr_year    = year_q;
  assign bus.nhuan        = nhuan_reg;
  assign bus.done_month   = done_month_reg;
  assign bus.done_century = done_century_reg;

endmodule
